// File: rtl/ssm_pkg.sv
// Shared SSM package: width helpers used by accum_n and the tile packer,
// plus the packer's IDLE/FILL state encoding.
package ssm_pkg;

   // Tile packer state: IDLE means no beat held and an all-zero fill buffer.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } hcp_state_t;

   // ceil(log2(v)); 0 for v <= 1 (accum_n sizing).
   function automatic int ceil_log2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Counter width for v states; never narrower than one bit.
   function automatic int clog2(input int v);
      return (v <= 1) ? 1 : ceil_log2(v);
   endfunction

endpackage

// File: rtl/hc_tile_packer.sv
// Packs K_LANE-wide hC beats into a full N_TILE tile for accum_n.
// Beat b lands at n = b*K_LANE + k; a tile is emitted on in_last_i or on
// the final beat position, whichever comes first.
module hc_tile_packer
   import ssm_pkg::*;
#(
   parameter int DW     = 16,
   parameter int H_TILE = 1,
   parameter int P_TILE = 1,
   parameter int N_TILE = 128,
   parameter int K_LANE = 8
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic                              clr_i,
   input  logic                              in_valid_i,
   output logic                              in_ready_o,
   input  logic [H_TILE*P_TILE*K_LANE*DW-1:0] in_data_i,
   input  logic                              in_last_i,
   output logic [H_TILE*P_TILE*N_TILE*DW-1:0] hC_o,
   output logic                              valid_o,
   output logic                              busy_o,
   output logic                              err_o,
   output logic [15:0]                       tile_cnt_o
);

   localparam int HP    = H_TILE * P_TILE;
   localparam int NBEAT = N_TILE / K_LANE;
   localparam int BW    = clog2(NBEAT);
   localparam int TW    = HP * N_TILE * DW;
   localparam logic [BW-1:0] BLAST = BW'(NBEAT - 1);

   if ((N_TILE % K_LANE) != 0) begin : g_bad_cfg
      $error("hc_tile_packer: N_TILE must be a multiple of K_LANE");
   end

   hcp_state_t    state, state_nxt;
   logic [BW-1:0] bcnt;
   logic [TW-1:0] fill_q;
   logic [TW-1:0] merged;
   logic          acc, at_end, done;

   // Clear takes priority over a same-cycle beat by dropping ready.
   assign in_ready_o = rstn & ~clr_i;
   assign acc        = in_valid_i & in_ready_o;
   assign at_end     = (bcnt == BLAST);
   assign done       = acc & (in_last_i | at_end);
   assign busy_o     = (state == ST_FILL);

   // Fill buffer merged with the beat being accepted this cycle.
   for (genvar hp = 0; hp < HP; hp++) begin : g_hp
      for (genvar bb = 0; bb < NBEAT; bb++) begin : g_b
         for (genvar k = 0; k < K_LANE; k++) begin : g_k
            localparam int N = bb * K_LANE + k;
            assign merged[DW*(hp*N_TILE+N) +: DW] =
               (acc && bcnt == BW'(bb)) ? in_data_i[DW*(hp*K_LANE+k) +: DW]
                                        : fill_q[DW*(hp*N_TILE+N) +: DW];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next state: clear or completion returns to IDLE, any other beat fills.
   always_comb begin
      state_nxt = state;
      if (clr_i)     state_nxt = ST_IDLE;
      else if (done) state_nxt = ST_IDLE;
      else if (acc)  state_nxt = ST_FILL;
   end

   // Datapath: fill buffer, beat counter, emitted tile and status pulses.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fill_q     <= '0;
         bcnt       <= '0;
         hC_o       <= '0;
         valid_o    <= 1'b0;
         err_o      <= 1'b0;
         tile_cnt_o <= '0;
      end else begin
         valid_o <= 1'b0;
         err_o   <= 1'b0;
         if (clr_i) begin
            fill_q <= '0;
            bcnt   <= '0;
            err_o  <= (state == ST_FILL);
         end else if (done) begin
            hC_o       <= merged;
            fill_q     <= '0;
            bcnt       <= '0;
            valid_o    <= 1'b1;
            err_o      <= at_end & ~in_last_i;
            tile_cnt_o <= tile_cnt_o + 16'd1;
         end else if (acc) begin
            fill_q <= merged;
            bcnt   <= bcnt + BW'(1);
         end
      end
   end

endmodule

// File: tb/tb_hc_tile_packer.sv
// Directed bench for hc_tile_packer at default parameters (16 beats x 8).
module tb_hc_tile_packer;

   localparam int DW = 16;
   localparam int N  = 128;
   localparam int K  = 8;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            clr_i = 1'b0;
   logic            in_valid_i = 1'b0;
   logic            in_ready_o;
   logic [K*DW-1:0] in_data_i = '0;
   logic            in_last_i = 1'b0;
   logic [N*DW-1:0] hC_o;
   logic            valid_o, busy_o, err_o;
   logic [15:0]     tile_cnt_o;

   int n_cmp = 0;
   int n_bad = 0;

   // Pulse monitor, sampled on the falling edge.
   int cyc = 0, vcnt = 0, ecnt = 0, vlast = 0, vprev = 0, rlo = 0;

   hc_tile_packer #(.DW(DW), .H_TILE(1), .P_TILE(1), .N_TILE(N), .K_LANE(K)) dut (
      .clk(clk), .rstn(rstn), .clr_i(clr_i), .in_valid_i(in_valid_i),
      .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_last_i(in_last_i),
      .hC_o(hC_o), .valid_o(valid_o), .busy_o(busy_o), .err_o(err_o),
      .tile_cnt_o(tile_cnt_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (valid_o) begin vcnt++; vprev = vlast; vlast = cyc; end
      if (err_o) ecnt++;
      if (rstn && !in_ready_o) rlo++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] hce(input int n);
      return hC_o[DW*n +: DW];
   endfunction

   task automatic put(input logic [K*DW-1:0] d, input logic last, input logic clr);
      in_valid_i = 1'b1; in_data_i = d; in_last_i = last; clr_i = clr;
   endtask

   task automatic idle();
      in_valid_i = 1'b0; in_data_i = '0; in_last_i = 1'b0; clr_i = 1'b0;
   endtask

   // Beat b with element k = base + b*8 + k.
   function automatic logic [K*DW-1:0] seq_beat(input int b, input logic [15:0] base);
      logic [K*DW-1:0] d;
      for (int k = 0; k < K; k++) d[DW*k +: DW] = base + 16'(b*K + k);
      return d;
   endfunction

   function automatic logic [K*DW-1:0] const_beat(input logic [15:0] v);
      logic [K*DW-1:0] d;
      for (int k = 0; k < K; k++) d[DW*k +: DW] = v;
      return d;
   endfunction

   task automatic chk_seq_tile(input string tag);
      int bad;
      bad = 0;
      for (int n = 0; n < N; n++) if (hce(n) !== 16'(n)) bad++;
      chk(tag, bad, 0);
   endtask

   int v0, e0, r0, bad;

   initial begin
      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_hc_or", 32'(|hC_o), 0);
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_err", 32'(err_o), 0);
      chk("rst_cnt", 32'(tile_cnt_o), 0);
      chk("rst_ready", 32'(in_ready_o), 0);
      rstn = 1'b1;

      // Full tile with in_last on beat 15.
      e0 = ecnt; v0 = vcnt;
      for (int b = 0; b < 16; b++) begin
         @(negedge clk);
         if (b == 4) chk("full_busy", 32'(busy_o), 1);
         put(seq_beat(b, 16'h0000), b == 15, 1'b0);
      end
      @(negedge clk);
      chk("full_valid", 32'(valid_o), 1);
      chk("full_err", 32'(err_o), 0);
      chk("full_busy_end", 32'(busy_o), 0);
      chk("full_cnt", 32'(tile_cnt_o), 1);
      chk_seq_tile("full_hc_bad_elems");
      idle();
      @(negedge clk);
      chk("full_valid_1cyc", 32'(valid_o), 0);
      chk("full_npulse", 32'(vcnt - v0), 1);
      chk("full_nerr", 32'(ecnt - e0), 0);

      // Early last after 3 beats: tail reads as +0.0.
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         put(seq_beat(b, 16'hA000), b == 2, 1'b0);
      end
      @(negedge clk);
      chk("early_valid", 32'(valid_o), 1);
      chk("early_err", 32'(err_o), 0);
      chk("early_cnt", 32'(tile_cnt_o), 2);
      bad = 0;
      for (int n = 0; n < N; n++)
         if (hce(n) !== ((n < 24) ? 16'hA000 + 16'(n) : 16'h0000)) bad++;
      chk("early_hc_bad_elems", bad, 0);
      idle();

      // Missing last: final beat position still emits, with err.
      for (int b = 0; b < 16; b++) begin
         @(negedge clk);
         put(seq_beat(b, 16'h5000), 1'b0, 1'b0);
      end
      @(negedge clk);
      chk("miss_valid", 32'(valid_o), 1);
      chk("miss_err", 32'(err_o), 1);
      chk("miss_cnt", 32'(tile_cnt_o), 3);
      chk("miss_hc127", 32'(hce(127)), 32'h507F);
      idle();
      @(negedge clk);
      chk("miss_err_1cyc", 32'(err_o), 0);

      // Back-to-back: 32 beats, two tiles, no gap.
      v0 = vcnt; r0 = rlo;
      for (int b = 0; b < 32; b++) begin
         @(negedge clk);
         if (b == 16) begin
            chk("b2b_a_valid", 32'(valid_o), 1);
            chk("b2b_a_hc0", 32'(hce(0)), 32'h3C00);
            chk("b2b_a_hc127", 32'(hce(127)), 32'h3C00);
         end
         put(const_beat((b < 16) ? 16'h3C00 : 16'h4000), (b % 16) == 15, 1'b0);
      end
      @(negedge clk);
      chk("b2b_b_valid", 32'(valid_o), 1);
      chk("b2b_b_hc0", 32'(hce(0)), 32'h4000);
      chk("b2b_b_hc127", 32'(hce(127)), 32'h4000);
      chk("b2b_cnt", 32'(tile_cnt_o), 5);
      idle();
      @(negedge clk);
      chk("b2b_npulse", 32'(vcnt - v0), 2);
      chk("b2b_spacing", 32'(vlast - vprev), 16);
      chk("b2b_ready_low", 32'(rlo - r0), 0);

      // Clear after 5 beats, with a beat offered alongside the clear.
      for (int b = 0; b < 5; b++) begin
         @(negedge clk);
         put(const_beat(16'hDEAD), 1'b0, 1'b0);
      end
      @(negedge clk);
      put(const_beat(16'hBEEF), 1'b0, 1'b1);
      #1 chk("clr_ready", 32'(in_ready_o), 0);
      @(negedge clk);
      chk("clr_err", 32'(err_o), 1);
      chk("clr_busy", 32'(busy_o), 0);
      chk("clr_valid", 32'(valid_o), 0);
      chk("clr_cnt", 32'(tile_cnt_o), 5);
      chk("clr_hc_kept", 32'(hce(0)), 32'h4000);
      for (int b = 0; b < 16; b++) begin
         if (b > 0) @(negedge clk);
         put(seq_beat(b, 16'h0000), b == 15, 1'b0);
      end
      @(negedge clk);
      chk("clr_next_valid", 32'(valid_o), 1);
      chk("clr_next_err", 32'(err_o), 0);
      chk("clr_next_cnt", 32'(tile_cnt_o), 6);
      chk_seq_tile("clr_next_hc_bad_elems");
      idle();

      // Reset in the middle of a tile.
      for (int b = 0; b < 7; b++) begin
         @(negedge clk);
         put(seq_beat(b, 16'h7000), 1'b0, 1'b0);
      end
      @(negedge clk);
      idle();
      e0 = ecnt; v0 = vcnt;
      rstn = 1'b0;
      #1;
      chk("mrst_hc_or", 32'(|hC_o), 0);
      chk("mrst_cnt", 32'(tile_cnt_o), 0);
      chk("mrst_busy", 32'(busy_o), 0);
      chk("mrst_valid", 32'(valid_o), 0);
      chk("mrst_err", 32'(err_o), 0);
      chk("mrst_ready", 32'(in_ready_o), 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("mrst_no_pulse", 32'((ecnt - e0) + (vcnt - v0)), 0);

      // Counter wrap: 65535 single-beat tiles, then one more.
      for (int i = 0; i < 65535; i++) begin
         @(negedge clk);
         if (i == 1) begin
            chk("wrap_first_hc0", 32'(hce(0)), 32'h1000);
            chk("wrap_first_hc8", 32'(hce(8)), 32'h0000);
         end
         put(seq_beat(0, 16'h1000), 1'b1, 1'b0);
      end
      @(negedge clk);
      chk("wrap_cnt_max", 32'(tile_cnt_o), 32'hFFFF);
      put(seq_beat(0, 16'h2000), 1'b1, 1'b0);
      @(negedge clk);
      chk("wrap_valid", 32'(valid_o), 1);
      chk("wrap_cnt_zero", 32'(tile_cnt_o), 0);
      chk("wrap_hc0", 32'(hce(0)), 32'h2000);
      idle();
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
